// File: rtl/acorn128_ctrl.sv
// ACORN-128 encryption sequencer.
// Walks the cipher through initialisation, associated data, padding,
// encryption and finalisation. For every cycle it tells the 293-bit
// state datapath whether to step, which control bits (ca/cb) to use
// and where the step's message bit comes from.
module acorn128_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             step_en,
    output logic             ca,
    output logic             cb,
    output logic [2:0]       m_sel,
    output logic [6:0]       bit_idx,
    output logic             ks_valid,
    output logic             tag_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD,
        S_AD_PAD,
        S_ENC,
        S_ENC_PAD,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [2:0] M_ZERO     = 3'd0;
    localparam logic [2:0] M_KEY      = 3'd1;
    localparam logic [2:0] M_IV       = 3'd2;
    localparam logic [2:0] M_KEY_XOR1 = 3'd3;
    localparam logic [2:0] M_DIN      = 3'd4;
    localparam logic [2:0] M_PAD1     = 3'd5;

    // Last step index of each fixed-length phase.
    localparam logic [10:0] INIT_LAST = 11'd1791;
    localparam logic [10:0] PAD_LAST  = 11'd255;
    localparam logic [10:0] FIN_LAST  = 11'd767;
    // The tag is the keystream of the final 128 finalisation steps.
    localparam logic [10:0] TAG_FIRST = 11'd640;

    state_t           state_q;
    logic [10:0]      step_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] ad_len_q;
    logic [LEN_W-1:0] msg_len_q;
    logic             ks_valid_q;
    logic             tag_valid_q;

    logic             ad_last;
    logic             msg_last;

    // An accepted input bit that completes the AD / plaintext block.
    assign ad_last  = (len_q == ad_len_q - LEN_W'(1));
    assign msg_last = (len_q == msg_len_q - LEN_W'(1));

    // Per-step datapath controls decoded from the current phase and step.
    always_comb begin
        step_en   = 1'b0;
        din_ready = 1'b0;
        ca        = 1'b0;
        cb        = 1'b0;
        m_sel     = M_ZERO;
        bit_idx   = 7'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_INIT: begin
                busy    = 1'b1;
                step_en = 1'b1;
                ca      = 1'b1;
                cb      = 1'b1;
                bit_idx = step_q[6:0];
                if (step_q < 11'd128)       m_sel = M_KEY;
                else if (step_q < 11'd256)  m_sel = M_IV;
                else if (step_q == 11'd256) m_sel = M_KEY_XOR1;
                else                        m_sel = M_KEY;
            end
            S_AD: begin
                busy      = 1'b1;
                din_ready = 1'b1;
                step_en   = din_valid;
                m_sel     = M_DIN;
                ca        = 1'b1;
                cb        = 1'b1;
            end
            S_AD_PAD, S_ENC_PAD: begin
                busy    = 1'b1;
                step_en = 1'b1;
                m_sel   = (step_q == 11'd0) ? M_PAD1 : M_ZERO;
                ca      = (step_q < 11'd128);
                cb      = (state_q == S_AD_PAD);
            end
            S_ENC: begin
                busy      = 1'b1;
                din_ready = 1'b1;
                step_en   = din_valid;
                m_sel     = M_DIN;
                ca        = 1'b1;
                cb        = 1'b0;
            end
            S_FIN: begin
                busy    = 1'b1;
                step_en = 1'b1;
                ca      = 1'b1;
                cb      = 1'b1;
                m_sel   = M_ZERO;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Phase sequencing, step/length counters and the one-cycle-late
    // keystream/tag qualifiers that line up with the registered keystream bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            len_q       <= '0;
            ad_len_q    <= '0;
            msg_len_q   <= '0;
            ks_valid_q  <= 1'b0;
            tag_valid_q <= 1'b0;
        end else begin
            ks_valid_q  <= 1'b0;
            tag_valid_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                step_q  <= '0;
                len_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            ad_len_q  <= ad_len;
                            msg_len_q <= msg_len;
                            step_q    <= '0;
                            len_q     <= '0;
                            state_q   <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        if (step_q == INIT_LAST) begin
                            step_q  <= '0;
                            state_q <= (ad_len_q == '0) ? S_AD_PAD : S_AD;
                        end else begin
                            step_q <= step_q + 11'd1;
                        end
                    end
                    S_AD: begin
                        if (din_valid) begin
                            if (ad_last) begin
                                len_q   <= '0;
                                state_q <= S_AD_PAD;
                            end else begin
                                len_q <= len_q + LEN_W'(1);
                            end
                        end
                    end
                    S_AD_PAD: begin
                        if (step_q == PAD_LAST) begin
                            step_q  <= '0;
                            state_q <= (msg_len_q == '0) ? S_ENC_PAD : S_ENC;
                        end else begin
                            step_q <= step_q + 11'd1;
                        end
                    end
                    S_ENC: begin
                        ks_valid_q <= din_valid;
                        if (din_valid) begin
                            if (msg_last) begin
                                len_q   <= '0;
                                state_q <= S_ENC_PAD;
                            end else begin
                                len_q <= len_q + LEN_W'(1);
                            end
                        end
                    end
                    S_ENC_PAD: begin
                        if (step_q == PAD_LAST) begin
                            step_q  <= '0;
                            state_q <= S_FIN;
                        end else begin
                            step_q <= step_q + 11'd1;
                        end
                    end
                    S_FIN: begin
                        tag_valid_q <= (step_q >= TAG_FIRST);
                        if (step_q == FIN_LAST) begin
                            step_q  <= '0;
                            state_q <= S_DONE;
                        end else begin
                            step_q <= step_q + 11'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ks_valid  = ks_valid_q;
    assign tag_valid = tag_valid_q;

endmodule

// File: tb/tb_acorn128_ctrl.sv
// Bench for acorn128_ctrl: a flat list of expected cipher steps is built
// from the phase rules on every accepted start and consumed one entry per
// step, driving a cycle-by-cycle comparison of all outputs.
module tb_acorn128_ctrl;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] ad_len;
    logic [LEN_W-1:0] msg_len;
    logic             din_valid;
    logic             din_ready;
    logic             step_en;
    logic             ca;
    logic             cb;
    logic [2:0]       m_sel;
    logic [6:0]       bit_idx;
    logic             ks_valid;
    logic             tag_valid;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    acorn128_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ad_len    (ad_len),
        .msg_len   (msg_len),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .step_en   (step_en),
        .ca        (ca),
        .cb        (cb),
        .m_sel     (m_sel),
        .bit_idx   (bit_idx),
        .ks_valid  (ks_valid),
        .tag_valid (tag_valid),
        .busy      (busy),
        .done      (done)
    );

    // One expected cipher step: does it wait for input, is it a
    // ciphertext/tag step, and the controls it must present.
    typedef struct packed {
        logic       din;
        logic       enc;
        logic       tag;
        logic [2:0] m;
        logic       ca;
        logic       cb;
        logic [6:0] bi;
    } step_t;

    int          n_checks = 0;
    int          n_errors = 0;

    step_t       q[$];
    int          mode = 0;        // 0 idle, 1 running, 2 done cycle
    int          steps_done = 0;
    logic        ks_e = 1'b0;
    logic        tag_e = 1'b0;
    logic [17:0] dut_vec;

    assign dut_vec = {busy, done, din_ready, step_en, ks_valid, tag_valid,
                      m_sel, ca, cb, bit_idx};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic din, input logic enc, input logic tg,
                        input logic [2:0] m, input logic a, input logic b, input logic [6:0] bi);
        step_t s;
        s.din = din; s.enc = enc; s.tag = tg; s.m = m; s.ca = a; s.cb = b; s.bi = bi;
        q.push_back(s);
    endtask

    task automatic build(input int ad, input int msg);
        q.delete();
        steps_done = 0;
        for (int i = 0; i < 1792; i++) begin
            logic [2:0] m;
            m = (i < 128) ? 3'd1 : (i < 256) ? 3'd2 : (i == 256) ? 3'd3 : 3'd1;
            push(1'b0, 1'b0, 1'b0, m, 1'b1, 1'b1, 7'(i % 128));
        end
        for (int i = 0; i < ad; i++)  push(1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 7'd0);
        for (int i = 0; i < 256; i++) push(1'b0, 1'b0, 1'b0, (i == 0) ? 3'd5 : 3'd0, i < 128, 1'b1, 7'd0);
        for (int i = 0; i < msg; i++) push(1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 256; i++) push(1'b0, 1'b0, 1'b0, (i == 0) ? 3'd5 : 3'd0, i < 128, 1'b0, 7'd0);
        for (int i = 0; i < 768; i++) push(1'b0, 1'b0, i >= 640, 3'd0, 1'b1, 1'b1, 7'd0);
    endtask

    function automatic logic [17:0] exp_vec(input logic dv);
        step_t h;
        if (mode == 1 && q.size() > 0) begin
            h = q[0];
            return {1'b1, 1'b0, h.din, (h.din ? dv : 1'b1), ks_e, tag_e, h.m, h.ca, h.cb, h.bi};
        end
        if (mode == 2) return {1'b0, 1'b1, 2'b00, ks_e, tag_e, 12'd0};
        return {4'b0000, ks_e, tag_e, 12'd0};
    endfunction

    task automatic model_reset();
        q.delete();
        mode  = 0;
        ks_e  = 1'b0;
        tag_e = 1'b0;
    endtask

    // Advance the reference model across one rising edge.
    task automatic model_edge(input logic r, input logic st, input logic ab, input logic dv,
                              input int ad, input int msg);
        step_t h;
        logic  took;
        logic  nks;
        logic  ntag;
        took = 1'b0; nks = 1'b0; ntag = 1'b0;
        if (r) begin
            model_reset();
            return;
        end
        if (mode == 1) begin
            h = q[0];
            took = !h.din || dv;
            if (took) begin
                nks  = h.enc;
                ntag = h.tag;
            end
        end
        if (ab) begin
            model_reset();
            return;
        end
        ks_e  = nks;
        tag_e = ntag;
        case (mode)
            0: if (st) begin
                build(ad, msg);
                mode = 1;
            end
            1: if (took) begin
                void'(q.pop_front());
                steps_done++;
                if (q.size() == 0) mode = 2;
            end
            default: mode = 0;
        endcase
    endtask

    // One start-to-idle sequence. dvm: 0 random din_valid, 1 always valid,
    // 2 ten-cycle gap after two plaintext bits. abort_at / rst_at give the
    // step index at which to abort or pulse reset (-1 for none).
    task automatic run_seq(input string name, input int ad, input int msg, input int dvm,
                           input int abort_at, input int rst_at, input bit junk,
                           output int o_steps, output int o_hs, output int o_ks,
                           output int o_tag, output int o_done);
        int cyc    = 0;
        int stalls = 0;
        bit fin    = 0;
        bit did_rst = 0;
        o_steps = 0; o_hs = 0; o_ks = 0; o_tag = 0; o_done = -1;
        ad_len    = LEN_W'(ad);
        msg_len   = LEN_W'(msg);
        start     = 1'b1;
        abort     = 1'b0;
        din_valid = (dvm == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin && cyc < 8000) begin
            if (rst_at >= 0 && !did_rst && mode == 1 && steps_done == rst_at) begin
                did_rst = 1;
                #1 rst = 1'b1;
                model_reset();
                #1 chk({name, "_async_rst"}, 32'(dut_vec), 32'd0);
            end
            @(negedge clk);
            chk(name, 32'(dut_vec), 32'(exp_vec(din_valid)));
            o_steps += int'(step_en);
            o_hs    += int'(din_ready && din_valid);
            o_ks    += int'(ks_valid);
            o_tag   += int'(tag_valid);
            if (done) o_done = cyc;
            model_edge(rst, start, abort, din_valid, ad, msg);
            @(posedge clk);
            #1;
            cyc++;
            rst = 1'b0;
            if (mode == 0) fin = 1;
            start = !fin && junk && mode == 1 && ($urandom_range(0, 15) == 0);
            abort = !fin && abort_at >= 0 && mode == 1 && steps_done == abort_at;
            case (dvm)
                0: din_valid = ($urandom_range(0, 9) < 7);
                1: din_valid = 1'b1;
                default: begin
                    if (mode == 1 && steps_done == 2048 + ad + 2 && stalls < 10) begin
                        din_valid = 1'b0;
                        stalls++;
                    end else begin
                        din_valid = 1'b1;
                    end
                end
            endcase
        end
        chk({name, "_terminated"}, 32'(fin), 32'd1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int s, h, k, t, d;
        int a, m;
        rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
        ad_len = '0; msg_len = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 32'(dut_vec), 32'd0);
        rst = 1'b0;
        model_reset();

        // Idle: input activity without start must not wake the block.
        for (int i = 0; i < 6; i++) begin
            din_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle", 32'(dut_vec), 32'(exp_vec(din_valid)));
            model_edge(rst, start, abort, din_valid, 0, 0);
            @(posedge clk);
            #1;
        end

        run_seq("zero_len", 0, 0, 0, -1, -1, 0, s, h, k, t, d);
        chk("zero_steps", s, 3072);
        chk("zero_tags", t, 128);
        chk("zero_handshakes", h, 0);
        chk("zero_done_cycle", d, 3073);

        run_seq("ad8_msg16", 8, 16, 1, -1, -1, 0, s, h, k, t, d);
        chk("ad8_steps", s, 3096);
        chk("ad8_handshakes", h, 24);
        chk("ad8_ks", k, 16);
        chk("ad8_tags", t, 128);
        chk("ad8_done_cycle", d, 3097);

        run_seq("enc_stall", 0, 4, 2, -1, -1, 0, s, h, k, t, d);
        chk("stall_steps", s, 3076);
        chk("stall_ks", k, 4);
        chk("stall_done_cycle", d, 3087);

        run_seq("fin_abort", 3, 5, 0, 2312 + 700, -1, 1, s, h, k, t, d);
        chk("abort_steps", s, 3013);
        chk("abort_tags", t, 60);
        chk("abort_no_done", d, -1);

        a = $urandom_range(0, 12);
        m = $urandom_range(0, 12);
        run_seq("post_abort", a, m, 0, -1, -1, 1, s, h, k, t, d);
        chk("post_abort_steps", s, 3072 + a + m);
        chk("post_abort_handshakes", h, a + m);
        chk("post_abort_ks", k, m);
        chk("post_abort_tags", t, 128);

        run_seq("ad_rst", 10, 6, 0, -1, 1796, 1, s, h, k, t, d);
        chk("rst_no_done", d, -1);

        for (int r = 0; r < 2; r++) begin
            a = $urandom_range(0, 20);
            m = $urandom_range(0, 20);
            run_seq("random", a, m, 0, -1, -1, 1, s, h, k, t, d);
            chk("random_steps", s, 3072 + a + m);
            chk("random_handshakes", h, a + m);
            chk("random_ks", k, m);
            chk("random_tags", t, 128);
            chk("random_done_seen", d > 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acorn128_ctrl.md
ACORN128_CTRL -- requirements
Module: acorn128_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the AD and message bit-length inputs.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin an encryption; sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-006 SHALL have port ad_len  input  LEN_W  associated-data length in bits, latched on accepted start.
REQ-007 SHALL have port msg_len  input  LEN_W  plaintext length in bits, latched on accepted start.
REQ-008 SHALL have port din_valid  input  1  serial AD/plaintext bit available.
REQ-009 SHALL have port din_ready  output  1  controller consumes the input bit this cycle.
REQ-010 SHALL have port step_en  output  1  advance the 293-bit cipher state by one step.
REQ-011 SHALL have ports ca and cb  output  1 each  ACORN-128 state-update control bits for the current step.
REQ-012 SHALL have port m_sel  output  3  source of the step's message bit: 0 ZERO, 1 KEY, 2 IV, 3 KEY_XOR1, 4 DIN, 5 PAD1.
REQ-013 SHALL have port bit_idx  output  7  key/IV bit index for the current step.
REQ-014 SHALL have ports ks_valid and tag_valid  output  1 each  registered keystream bit is a ciphertext mask / tag bit.
REQ-015 SHALL have ports busy and done  output  1 each  operation in progress / one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, INIT, AD, AD_PAD, ENC, ENC_PAD, FIN, DONE with a single step counter (11 bits) and a length counter (LEN_W bits).
REQ-017 IDLE: start latches lengths, clears counters, enters INIT next cycle; busy=1 from INIT through FIN.
REQ-018 INIT: exactly 1792 steps, step_en=1 every cycle, ca=cb=1.
REQ-019 INIT m_sel: KEY for steps 0-127, IV for 128-255, KEY_XOR1 for step 256, KEY for 257-1791; bit_idx = step[6:0].
REQ-020 AD: din_ready=1; step_en = din_valid; m_sel=DIN; ca=cb=1; exits after ad_len accepted bits; ad_len=0 skips directly to AD_PAD.
REQ-021 AD_PAD: 256 steps, step_en=1; m_sel=PAD1 on step 0, ZERO otherwise; ca=1 for steps 0-127, ca=0 for 128-255; cb=1.
REQ-022 ENC: din_ready=1; step_en = din_valid; m_sel=DIN; ca=1, cb=0; exits after msg_len accepted bits; msg_len=0 skips to ENC_PAD.
REQ-023 ENC_PAD: 256 steps as AD_PAD except cb=0.
REQ-024 FIN: 768 steps, step_en=1, ca=cb=1, m_sel=ZERO.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 din_ready SHALL be 0 outside AD/ENC; a stalled din_valid=0 SHALL hold all counters and outputs unchanged.
REQ-027 ks_valid SHALL equal ENC step_en delayed one cycle; tag_valid SHALL equal FIN step_en for steps 640-767 delayed one cycle, giving exactly 128 tag bits.
REQ-028 start while not IDLE SHALL be ignored.
REQ-029 abort SHALL force IDLE next cycle with step_en, din_ready, ks_valid, tag_valid=0 and no done pulse; abort has priority over start.
REQ-030 Phase-final step SHALL transition on the same edge as its last step_en; no idle cycle between phases.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, clear counters and latched lengths, and drive step_en, din_ready, ca, cb, ks_valid, tag_valid, busy, done=0, m_sel=0, bit_idx=0.
REQ-032 Release of rst mid-operation SHALL leave the block in IDLE awaiting start.

Verification
REQ-033 ad_len=0, msg_len=0, start -> exactly 3072 step_en pulses, 128 tag_valid pulses, done 3073 cycles after start.
REQ-034 ad_len=8, msg_len=16, din_valid=1 constantly -> 3096 step_en, 8 AD and 16 ENC din_ready handshakes, 16 ks_valid pulses.
REQ-035 INIT sequence check -> m_sel=1 at step 0, 2 at step 128, 3 at step 256, 1 at step 257 with bit_idx=1.
REQ-036 msg_len=4 with din_valid low for 10 cycles mid-ENC -> step count unchanged, total cycles +10.
REQ-037 abort at FIN step 700 -> IDLE next cycle, tag_valid stops, no done; next start runs a full sequence.
REQ-038 rst pulse during AD, start during INIT -> outputs zero immediately on rst; start while busy leaves sequence unaffected.
